t02_wb_arbiter_manager: RTL and testbench

Parametrised multi-channel Wishbone bus manager. It generalises the single-requester manager so that NCH independent CPU-side request channels (e.g. instruction fetch, data load/store, DMA) share one Wishbone master port. A fair round-robin arbiter sits in front of the bus, and an optional bus timeout reports hung slaves per channel. It sits between the t02 core and the Caravel Wishbone bus.

---
 rtl/t02_wb_pkg.sv | 14 +
 rtl/t02_rr_arbiter.sv | 28 ++
 rtl/t02_wb_arbiter_manager.sv | 160 ++++++++++++++++
 tb/tb_t02_wb_arbiter_manager.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/t02_wb_pkg.sv
// rtl/t02_wb_pkg.sv - shared types and widths for the t02 multi-channel Wishbone manager
package t02_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

endpackage

// File: rtl/t02_rr_arbiter.sv
// rtl/t02_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module t02_rr_arbiter #(
  parameter int NCH   = 2,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NCH-1:0]   grant,
  output logic             valid
);

  int idx;

  // Scan (last_grant+1) .. last_grant with wrap; last_grant itself is checked last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_grant) + k) % NCH;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t02_wb_arbiter_manager.sv
// rtl/t02_wb_arbiter_manager.sv - NCH-channel round-robin Wishbone master; optional bus timeout via T02_WB_TIMEOUT_EN
module t02_wb_arbiter_manager
  import t02_wb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [NCH-1:0]        req_read,
  input  logic [NCH-1:0]        req_write,
  input  logic [NCH*32-1:0]     req_adr,
  input  logic [NCH*32-1:0]     req_dat,
  input  logic [NCH*4-1:0]      req_sel,
  output logic [31:0]           rsp_dat,
  output logic [NCH-1:0]        rsp_valid,
  output logic [NCH-1:0]        rsp_err,
  output logic [NCH-1:0]        busy,
  output logic [31:0]           ADR_O,
  output logic [31:0]           DAT_O,
  output logic [3:0]            SEL_O,
  output logic                  WE_O,
  output logic                  STB_O,
  output logic                  CYC_O,
  input  logic [31:0]           DAT_I,
  input  logic                  ACK_I
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  wb_state_e        state_q, state_nx;
  logic [IDX_W-1:0] gnt_q, last_q, pick_idx;
  logic [NCH-1:0]   req_any, pick_oh, gnt_oh;
  logic             pick_valid;
  logic             start;
  logic             expire;

  assign req_any = req_read | req_write;

  t02_rr_arbiter #(.NCH(NCH), .IDX_W(IDX_W)) u_arb (
    .req       (req_any),
    .last_grant(last_q),
    .grant     (pick_oh),
    .valid     (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_oh[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      gnt_oh[i] = (gnt_q == IDX_W'(i));
    end
  end

  assign start = (state_q == IDLE) && en && pick_valid;

  // The completing channel is no longer busy during its rsp_valid cycle.
  assign busy = req_any & ~((state_q == DONE) ? gnt_oh : {NCH{1'b0}});

`ifdef T02_WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts completed ACK-less BUS cycles; the TIMEOUT-th one aborts unless ACK_I arrives.
  assign expire = (state_q == BUS) && !ACK_I && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (state_q == BUS && !ACK_I) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign expire         = 1'b0;
  assign rsp_err        = '0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (start) state_nx = BUS;
      BUS:     if (ACK_I || expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      gnt_q     <= '0;
      last_q    <= IDX_W'(NCH - 1);
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      rsp_dat   <= '0;
      rsp_valid <= '0;
`ifdef T02_WB_TIMEOUT_EN
      rsp_err   <= '0;
`endif
    end else begin
      rsp_valid <= '0;
`ifdef T02_WB_TIMEOUT_EN
      rsp_err   <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            gnt_q <= pick_idx;
            ADR_O <= req_adr[WB_ADDR_W*int'(pick_idx) +: WB_ADDR_W];
            DAT_O <= req_dat[WB_DATA_W*int'(pick_idx) +: WB_DATA_W];
            SEL_O <= req_sel[WB_SEL_W*int'(pick_idx) +: WB_SEL_W];
            WE_O  <= req_write[pick_idx];
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
          end
        end
        BUS: begin
          if (ACK_I) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_valid <= gnt_oh;
            if (!WE_O) rsp_dat <= DAT_I;
          end else if (expire) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            rsp_valid <= gnt_oh;
`ifdef T02_WB_TIMEOUT_EN
            rsp_err   <= gnt_oh;
`endif
          end
        end
        DONE: begin
          last_q <= gnt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t02_wb_arbiter_manager.sv
// tb/tb_t02_wb_arbiter_manager.sv - directed self-checking bench for the multi-channel Wishbone manager
module tb_t02_wb_arbiter_manager;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic              en;
  logic [NCH-1:0]    req_read, req_write;
  logic [NCH*32-1:0] req_adr, req_dat;
  logic [NCH*4-1:0]  req_sel;
  logic [31:0]       rsp_dat;
  logic [NCH-1:0]    rsp_valid, rsp_err, busy;
  logic [31:0]       ADR_O, DAT_O, DAT_I;
  logic [3:0]        SEL_O;
  logic              WE_O, STB_O, CYC_O, ACK_I;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_dat;
  logic [31:0] adr_tab [4] = '{32'h3000_0100, 32'h3000_0110, 32'h3000_0120, 32'h3000_0130};

  t02_wb_arbiter_manager #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .req_read(req_read), .req_write(req_write),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_dat(rsp_dat), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0; en = 1'b1; req_read = '0; req_write = '0;
    req_adr = '0; req_dat = '0; req_sel = '0; DAT_I = '0; ACK_I = 1'b0;
    cyc(); cyc();
    vectors++; if (CYC_O !== 1'b0) begin miscompares++; $display("FAIL reset_cyc got %b want 0", CYC_O); end
    vectors++; if (STB_O !== 1'b0) begin miscompares++; $display("FAIL reset_stb got %b want 0", STB_O); end
    vectors++; if (WE_O !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", WE_O); end
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    vectors++; if (busy !== 4'b0000) begin miscompares++; $display("FAIL reset_busy got %b want 0000", busy); end
    vectors++; if (ADR_O !== 32'h0 || rsp_dat !== 32'h0) begin miscompares++; $display("FAIL reset_adr_dat got %h/%h want 0/0", ADR_O, rsp_dat); end
    nrst = 1'b1;
  endtask

  task automatic test_single_read;
    req_adr[31:0] = 32'h3000_0010;
    req_read = 4'b0001;
    cyc();
    vectors++; if (CYC_O !== 1'b1 || STB_O !== 1'b1) begin miscompares++; $display("FAIL read_cyc_stb got %b%b want 11", CYC_O, STB_O); end
    vectors++; if (ADR_O !== 32'h3000_0010) begin miscompares++; $display("FAIL read_adr got %h want 30000010", ADR_O); end
    vectors++; if (WE_O !== 1'b0) begin miscompares++; $display("FAIL read_we got %b want 0", WE_O); end
    vectors++; if (busy !== 4'b0001) begin miscompares++; $display("FAIL read_busy got %b want 0001", busy); end
    ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
    cyc();
    vectors++; if (rsp_valid !== 4'b0001) begin miscompares++; $display("FAIL read_rsp_valid got %b want 0001", rsp_valid); end
    vectors++; if (rsp_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rsp_dat got %h want deadbeef", rsp_dat); end
    vectors++; if (CYC_O !== 1'b0 || busy !== 4'b0000) begin miscompares++; $display("FAIL read_done got cyc=%b busy=%b want 0/0000", CYC_O, busy); end
    req_read = '0; ACK_I = 1'b0; DAT_I = '0;
    cyc();
    vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL read_pulse got %b want 0000", rsp_valid); end
  endtask

  task automatic test_write_wait;
    req_adr[63:32] = 32'h3000_0020;
    req_dat[63:32] = 32'h1234_5678;
    req_sel[7:4]   = 4'h3;
    req_write = 4'b0010;
    req_read  = 4'b0010;
    cyc();
    vectors++; if (WE_O !== 1'b1) begin miscompares++; $display("FAIL write_we got %b want 1", WE_O); end
    vectors++; if (ADR_O !== 32'h3000_0020) begin miscompares++; $display("FAIL write_adr got %h want 30000020", ADR_O); end
    req_dat[63:32] = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (DAT_O !== 32'h1234_5678 || SEL_O !== 4'h3 || CYC_O !== 1'b1) begin
        miscompares++; $display("FAIL write_stable[%0d] got %h/%h/%b want 12345678/3/1", k, DAT_O, SEL_O, CYC_O);
      end
      if (k == 3) ACK_I = 1'b1;
      cyc();
    end
    vectors++; if (rsp_valid !== 4'b0010) begin miscompares++; $display("FAIL write_rsp_valid got %b want 0010", rsp_valid); end
    vectors++; if (rsp_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write_rsp_dat got %h want deadbeef", rsp_dat); end
    req_read = '0; req_write = '0; ACK_I = 1'b0;
    cyc();
  endtask

  task automatic test_contention;
    int ch;
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    for (int i = 0; i < NCH; i++) req_adr[32*i +: 32] = adr_tab[i];
    req_read = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      ch = t % NCH;
      cyc();
      vectors++; if (CYC_O !== 1'b1 || ADR_O !== adr_tab[ch]) begin miscompares++; $display("FAIL rr_grant[%0d] got cyc=%b adr=%h want 1/%h", t, CYC_O, ADR_O, adr_tab[ch]); end
      ACK_I = 1'b1; DAT_I = 32'hA000_0000 + 32'(t);
      cyc();
      vectors++; if (rsp_valid !== (4'b0001 << ch)) begin miscompares++; $display("FAIL rr_valid[%0d] got %b want %b", t, rsp_valid, 4'b0001 << ch); end
      vectors++; if (busy !== (4'b1111 & ~(4'b0001 << ch))) begin miscompares++; $display("FAIL rr_busy[%0d] got %b want %b", t, busy, 4'b1111 & ~(4'b0001 << ch)); end
      vectors++; if (rsp_dat !== 32'hA000_0000 + 32'(t)) begin miscompares++; $display("FAIL rr_dat[%0d] got %h want %h", t, rsp_dat, 32'hA000_0000 + 32'(t)); end
      req_read[ch] = 1'b0; ACK_I = 1'b0;
      cyc();
      vectors++; if (CYC_O !== 1'b0) begin miscompares++; $display("FAIL rr_idle[%0d] got %b want 0", t, CYC_O); end
      req_read[ch] = 1'b1;
    end
    req_read = '0;
  endtask

  task automatic test_enable;
    req_adr[31:0] = 32'h3000_0040;
    en = 1'b0; req_read = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++; if (CYC_O !== 1'b0 || busy !== 4'b0001) begin miscompares++; $display("FAIL en_block[%0d] got cyc=%b busy=%b want 0/0001", k, CYC_O, busy); end
    end
    en = 1'b1;
    cyc();
    vectors++; if (CYC_O !== 1'b1 || ADR_O !== 32'h3000_0040) begin miscompares++; $display("FAIL en_grant got cyc=%b adr=%h want 1/30000040", CYC_O, ADR_O); end
    en = 1'b0;
    cyc();
    vectors++; if (CYC_O !== 1'b1) begin miscompares++; $display("FAIL en_drop_hold got %b want 1", CYC_O); end
    ACK_I = 1'b1; DAT_I = 32'h5555_AAAA;
    cyc();
    vectors++; if (rsp_valid !== 4'b0001 || rsp_dat !== 32'h5555_AAAA) begin miscompares++; $display("FAIL en_drop_done got %b/%h want 0001/5555aaaa", rsp_valid, rsp_dat); end
    req_read = '0; ACK_I = 1'b0;
    cyc();
    en = 1'b1;
    exp_dat = 32'h5555_AAAA;
  endtask

  task automatic test_timeout;
`ifdef T02_WB_TIMEOUT_EN
    req_read = 4'b0001;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k < 8) begin
        vectors++; if (CYC_O !== 1'b1) begin miscompares++; $display("FAIL to_hold[%0d] got %b want 1", k, CYC_O); end
      end
    end
    vectors++; if (CYC_O !== 1'b0) begin miscompares++; $display("FAIL to_cyc got %b want 0", CYC_O); end
    vectors++; if (rsp_valid !== 4'b0001 || rsp_err !== 4'b0001) begin miscompares++; $display("FAIL to_err got %b/%b want 0001/0001", rsp_valid, rsp_err); end
    vectors++; if (rsp_dat !== exp_dat) begin miscompares++; $display("FAIL to_dat got %h want %h", rsp_dat, exp_dat); end
    req_read = '0;
    cyc();
    req_read = 4'b0001;
    cyc();
    for (int k = 1; k < 8; k++) cyc();
    ACK_I = 1'b1; DAT_I = 32'h0BAD_F00D;
    cyc();
    vectors++; if (rsp_valid !== 4'b0001 || rsp_err !== 4'b0000 || rsp_dat !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL to_ack_wins got %b/%b/%h want 0001/0000/0badf00d", rsp_valid, rsp_err, rsp_dat); end
    req_read = '0; ACK_I = 1'b0;
    cyc();
`else
    req_read = 4'b0001;
    cyc();
    for (int k = 0; k < 100; k++) begin
      vectors++; if (CYC_O !== 1'b1) begin miscompares++; $display("FAIL nto_hold[%0d] got %b want 1", k, CYC_O); end
      cyc();
    end
    ACK_I = 1'b1; DAT_I = 32'h0BAD_F00D;
    cyc();
    vectors++; if (rsp_valid !== 4'b0001 || rsp_err !== 4'b0000 || rsp_dat !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL nto_done got %b/%b/%h want 0001/0000/0badf00d", rsp_valid, rsp_err, rsp_dat); end
    req_read = '0; ACK_I = 1'b0;
    cyc();
`endif
  endtask

  task automatic test_reset_mid_bus;
    req_adr[95:64] = 32'h3000_0080;
    req_read = 4'b0100;
    cyc();
    vectors++; if (CYC_O !== 1'b1 || ADR_O !== 32'h3000_0080) begin miscompares++; $display("FAIL rst_bus_start got %b/%h want 1/30000080", CYC_O, ADR_O); end
    nrst = 1'b0;
    cyc();
    vectors++; if (CYC_O !== 1'b0 || STB_O !== 1'b0 || ADR_O !== 32'h0) begin miscompares++; $display("FAIL rst_bus_abort got %b%b/%h want 00/0", CYC_O, STB_O, ADR_O); end
    nrst = 1'b1; req_read = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_contention();
    test_enable();
    test_timeout();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
